// File: rtl/moore_match_monitor.sv
`default_nettype none
// ============================================================================
// Module      : moore_match_monitor
// Description : Turns the level output of an upstream Moore sequence detector
//               into single match events, keeps a saturating total count,
//               counts matches inside a fixed-length window and raises a
//               fixed-length alarm when the window count reaches a threshold.
// Ports       : clk         - single clock, rising edge
//               rst         - asynchronous active-high reset
//               det         - detector level input
//               clr         - synchronous clear of counters and FSM
//               thresh      - window match count that raises alarm (0 = off)
//               match_pulse - one-cycle pulse per detected match
//               total_cnt   - saturating count of all matches
//               win_cnt     - matches counted in the current window
//               alarm       - high while in ALARM
// Revision    : 1.0 - initial release
// ============================================================================
module moore_match_monitor #(
    parameter int CNT_W = 8,
    parameter int WIN   = 16,
    parameter int HOLD  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             det,
    input  logic             clr,
    input  logic [CNT_W-1:0] thresh,
    output logic             match_pulse,
    output logic [CNT_W-1:0] total_cnt,
    output logic [CNT_W-1:0] win_cnt,
    output logic             alarm
);

    localparam int c_TW = (WIN  > 1) ? $clog2(WIN)  : 1;
    localparam int c_HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [c_TW-1:0]  c_TIMER_LAST = c_TW'(WIN - 1);
    localparam logic [c_HW-1:0]  c_HOLD_LAST  = c_HW'(HOLD - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_WINDOW = 2'd1;
    localparam logic [1:0] c_ST_ALARM  = 2'd2;

    logic             r_det_q;
    logic [1:0]       r_state;
    logic [c_TW-1:0]  r_timer;
    logic [c_HW-1:0]  r_hold;
    logic [CNT_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] r_total_cnt;
    logic             r_match_pulse;
    logic             r_alarm;

    logic [1:0]       w_state_nxt;
    logic [c_TW-1:0]  w_timer_nxt;
    logic [c_HW-1:0]  w_hold_nxt;
    logic [CNT_W-1:0] w_win_nxt;
    logic [CNT_W-1:0] w_total_nxt;
    logic             w_pulse_nxt;
    logic             w_alarm_nxt;

    // Rising edge of the detector level; a held-high level counts once.
    logic             w_event;
    logic [CNT_W-1:0] w_win_inc;
    logic [CNT_W-1:0] w_total_inc;
    logic             w_thresh_hit;

    assign w_event     = det & ~r_det_q;
    assign w_win_inc   = (r_win_cnt   == c_CNT_MAX) ? r_win_cnt   : r_win_cnt   + c_CNT_ONE;
    assign w_total_inc = (r_total_cnt == c_CNT_MAX) ? r_total_cnt : r_total_cnt + c_CNT_ONE;

    // Threshold is only evaluated when an event arrives, so a lowered
    // threshold never fires retroactively on an already-counted window.
    assign w_thresh_hit = w_event && (thresh != '0) && (w_win_inc >= thresh);

    // ------------------------------------------------------------------
    // State register (all registered state lives here)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_det_q       <= 1'b0;
            r_state       <= c_ST_IDLE;
            r_timer       <= '0;
            r_hold        <= '0;
            r_win_cnt     <= '0;
            r_total_cnt   <= '0;
            r_match_pulse <= 1'b0;
            r_alarm       <= 1'b0;
        end else begin
            r_det_q       <= det;
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_hold        <= w_hold_nxt;
            r_win_cnt     <= w_win_nxt;
            r_total_cnt   <= w_total_nxt;
            r_match_pulse <= w_pulse_nxt;
            r_alarm       <= w_alarm_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_hold_nxt  = r_hold;
        w_win_nxt   = r_win_cnt;
        if (clr) begin
            w_state_nxt = c_ST_IDLE;
            w_timer_nxt = '0;
            w_hold_nxt  = '0;
            w_win_nxt   = '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    w_timer_nxt = '0;
                    w_hold_nxt  = '0;
                    w_win_nxt   = '0;
                    if (w_event) begin
                        w_win_nxt   = c_CNT_ONE;
                        w_state_nxt = (thresh == c_CNT_ONE) ? c_ST_ALARM : c_ST_WINDOW;
                    end
                end
                c_ST_WINDOW: begin
                    // Threshold check wins over expiry so an event on the
                    // last window cycle can still raise the alarm.
                    if (w_thresh_hit) begin
                        w_state_nxt = c_ST_ALARM;
                        w_win_nxt   = w_win_inc;
                        w_hold_nxt  = '0;
                        w_timer_nxt = '0;
                    end else if (r_timer == c_TIMER_LAST) begin
                        w_state_nxt = c_ST_IDLE;
                        w_win_nxt   = '0;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                        if (w_event) begin
                            w_win_nxt = w_win_inc;
                        end
                    end
                end
                c_ST_ALARM: begin
                    if (r_hold == c_HOLD_LAST) begin
                        w_state_nxt = c_ST_IDLE;
                        w_win_nxt   = '0;
                        w_hold_nxt  = '0;
                    end else begin
                        w_hold_nxt = r_hold + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                    w_timer_nxt = '0;
                    w_hold_nxt  = '0;
                    w_win_nxt   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic (next values of the registered outputs)
    // ------------------------------------------------------------------
    always_comb begin
        w_alarm_nxt = (w_state_nxt == c_ST_ALARM);
        w_pulse_nxt = w_event & ~clr;
        w_total_nxt = r_total_cnt;
        if (clr) begin
            w_total_nxt = '0;
        end else if (w_event) begin
            w_total_nxt = w_total_inc;
        end
    end

    assign match_pulse = r_match_pulse;
    assign total_cnt   = r_total_cnt;
    assign win_cnt     = r_win_cnt;
    assign alarm       = r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_moore_match_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_moore_match_monitor
// Description : Self-checking bench for moore_match_monitor with a
//               behavioural reference model (window age / alarm countdown).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_moore_match_monitor;

    localparam int CNT_W = 8;
    localparam int WIN   = 16;
    localparam int HOLD  = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             det;
    logic             clr;
    logic [CNT_W-1:0] thresh;
    logic             match_pulse;
    logic [CNT_W-1:0] total_cnt;
    logic [CNT_W-1:0] win_cnt;
    logic             alarm;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_total, m_win, m_age, m_alarm_left;
    bit m_in_win, m_prev_det, m_pulse;

    moore_match_monitor #(.CNT_W(CNT_W), .WIN(WIN), .HOLD(HOLD)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .det         (det),
        .clr         (clr),
        .thresh      (thresh),
        .match_pulse (match_pulse),
        .total_cnt   (total_cnt),
        .win_cnt     (win_cnt),
        .alarm       (alarm)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_total = 0; m_win = 0; m_age = 0; m_alarm_left = 0;
        m_in_win = 0; m_prev_det = 0; m_pulse = 0;
    endtask

    task automatic model_edge(input bit d, input bit c);
        bit ev;
        int nw;
        ev = d && !m_prev_det;
        m_prev_det = d;
        if (c) begin
            m_total = 0; m_win = 0; m_age = 0; m_alarm_left = 0;
            m_in_win = 0; m_pulse = 0;
            return;
        end
        m_pulse = ev;
        if (ev && m_total < MAXC) m_total++;
        if (m_alarm_left > 0) begin
            m_alarm_left--;
            if (m_alarm_left == 0) m_win = 0;
        end else if (m_in_win) begin
            m_age++;
            nw = (ev && m_win < MAXC) ? m_win + 1 : m_win;
            if (ev && thresh != 0 && nw >= int'(thresh)) begin
                m_in_win = 0;
                m_alarm_left = HOLD;
                m_win = nw;
            end else if (m_age == WIN) begin
                m_in_win = 0;
                m_win = 0;
            end else begin
                m_win = nw;
            end
        end else if (ev) begin
            m_win = 1;
            if (thresh == 1) m_alarm_left = HOLD;
            else begin
                m_in_win = 1;
                m_age = 0;
            end
        end
    endtask

    // Drive one cycle's inputs, clock it, advance the model, sample at +1.
    task automatic step(input bit d, input bit c);
        det = d;
        clr = c;
        @(posedge clk);
        model_edge(d, c);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        det = 1'b0;
        clr = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; det = 1'b0; clr = 1'b0; thresh = 8'd3;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({match_pulse, alarm, total_cnt, win_cnt} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_state got pulse=%b alarm=%b total=%0d win=%0d exp all 0",
                     match_pulse, alarm, total_cnt, win_cnt);
        end
        // det already high when reset releases counts as an event
        det = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
        step(1'b1, 1'b0);
        n_checks++;
        if ({match_pulse, total_cnt, win_cnt} !== {1'b1, 8'd1, 8'd1}) begin
            n_fail++;
            $display("FAIL reset_release_event got pulse=%b total=%0d win=%0d exp pulse=1 total=1 win=1",
                     match_pulse, total_cnt, win_cnt);
        end
    endtask

    task automatic test_threshold_alarm();
        int pulses = 0, alarm_cycles = 0;
        do_reset();
        thresh = 8'd3;
        for (int cyc = 0; cyc < 16; cyc++) begin
            step(cyc == 2 || cyc == 5 || cyc == 8, 1'b0);
            pulses += match_pulse;
            alarm_cycles += alarm;
            n_checks++;
            if ({match_pulse, alarm, total_cnt, win_cnt} !==
                {m_pulse, (m_alarm_left > 0), 8'(m_total), 8'(m_win)}) begin
                n_fail++;
                $display("FAIL threshold_alarm cyc=%0d got p=%b a=%b t=%0d w=%0d exp p=%b a=%b t=%0d w=%0d",
                         cyc, match_pulse, alarm, total_cnt, win_cnt,
                         m_pulse, (m_alarm_left > 0), m_total, m_win);
            end
            if (cyc == 8) begin
                n_checks++;
                if (win_cnt !== 8'd3 || alarm !== 1'b1) begin
                    n_fail++;
                    $display("FAIL threshold_reach got win=%0d alarm=%b exp win=3 alarm=1", win_cnt, alarm);
                end
            end
        end
        n_checks++;
        if (pulses != 3 || alarm_cycles != HOLD || total_cnt !== 8'd3 || win_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL threshold_summary got pulses=%0d alarm_cycles=%0d total=%0d win=%0d exp 3 4 3 0",
                     pulses, alarm_cycles, total_cnt, win_cnt);
        end
    endtask

    task automatic test_window_expiry();
        int alarm_cycles = 0;
        do_reset();
        thresh = 8'd3;
        for (int cyc = 0; cyc < 26; cyc++) begin
            step(cyc == 0 || cyc == 20, 1'b0);
            alarm_cycles += alarm;
            n_checks++;
            if ({match_pulse, alarm, total_cnt, win_cnt} !==
                {m_pulse, (m_alarm_left > 0), 8'(m_total), 8'(m_win)}) begin
                n_fail++;
                $display("FAIL window_expiry cyc=%0d got p=%b a=%b t=%0d w=%0d exp p=%b a=%b t=%0d w=%0d",
                         cyc, match_pulse, alarm, total_cnt, win_cnt,
                         m_pulse, (m_alarm_left > 0), m_total, m_win);
            end
            if (cyc == 19) begin
                n_checks++;
                if (win_cnt !== 8'd0) begin
                    n_fail++;
                    $display("FAIL window_closed got win=%0d exp 0", win_cnt);
                end
            end
        end
        n_checks++;
        if (alarm_cycles != 0 || total_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL window_expiry_summary got alarm_cycles=%0d total=%0d exp 0 2",
                     alarm_cycles, total_cnt);
        end
    endtask

    task automatic test_held_level();
        int pulses = 0;
        do_reset();
        thresh = 8'd3;
        for (int cyc = 0; cyc < 15; cyc++) begin
            step(cyc < 10, 1'b0);
            pulses += match_pulse;
        end
        n_checks++;
        if (pulses != 1 || total_cnt !== 8'd1 || win_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL held_level got pulses=%0d total=%0d win=%0d exp 1 1 1",
                     pulses, total_cnt, win_cnt);
        end
    endtask

    task automatic test_saturation();
        int alarm_cycles = 0;
        do_reset();
        thresh = 8'd0;
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b0);
            alarm_cycles += alarm;
            step(1'b0, 1'b0);
            alarm_cycles += alarm;
        end
        n_checks++;
        if (total_cnt !== 8'd255 || total_cnt !== 8'(m_total) || alarm_cycles != 0) begin
            n_fail++;
            $display("FAIL saturation got total=%0d alarm_cycles=%0d exp total=255 alarm_cycles=0",
                     total_cnt, alarm_cycles);
        end
    endtask

    task automatic test_clear();
        do_reset();
        thresh = 8'd5;
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        n_checks++;
        if (win_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL clear_setup got win=%0d exp 2", win_cnt);
        end
        step(1'b1, 1'b1);
        n_checks++;
        if ({match_pulse, total_cnt, win_cnt, alarm} !== 18'd0) begin
            n_fail++;
            $display("FAIL clear_priority got pulse=%b total=%0d win=%0d alarm=%b exp all 0",
                     match_pulse, total_cnt, win_cnt, alarm);
        end
        // From IDLE a fresh event opens a window with win_cnt 1.
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        n_checks++;
        if ({match_pulse, total_cnt, win_cnt} !== {1'b1, 8'd1, 8'd1}) begin
            n_fail++;
            $display("FAIL clear_then_idle got pulse=%b total=%0d win=%0d exp 1 1 1",
                     match_pulse, total_cnt, win_cnt);
        end
    endtask

    task automatic test_rst_in_alarm();
        do_reset();
        thresh = 8'd1;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        n_checks++;
        if (alarm !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_alarm_setup got alarm=%b exp 1", alarm);
        end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({alarm, match_pulse, total_cnt, win_cnt} !== 18'd0) begin
            n_fail++;
            $display("FAIL async_reset got alarm=%b pulse=%b total=%0d win=%0d exp all 0",
                     alarm, match_pulse, total_cnt, win_cnt);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_back_to_back();
        do_reset();
        thresh = 8'd2;
        for (int cyc = 0; cyc < 40; cyc++) begin
            step(cyc[0] == 1'b0, 1'b0);
            n_checks++;
            if ({match_pulse, alarm, total_cnt, win_cnt} !==
                {m_pulse, (m_alarm_left > 0), 8'(m_total), 8'(m_win)}) begin
                n_fail++;
                $display("FAIL back_to_back cyc=%0d got p=%b a=%b t=%0d w=%0d exp p=%b a=%b t=%0d w=%0d",
                         cyc, match_pulse, alarm, total_cnt, win_cnt,
                         m_pulse, (m_alarm_left > 0), m_total, m_win);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        thresh = 8'd3;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 40 == 0) thresh = 8'($urandom_range(0, 5));
            step(($urandom % 3) == 0, ($urandom % 97) == 0);
            n_checks++;
            if ({match_pulse, alarm, total_cnt, win_cnt} !==
                {m_pulse, (m_alarm_left > 0), 8'(m_total), 8'(m_win)}) begin
                n_fail++;
                $display("FAIL random cyc=%0d th=%0d got p=%b a=%b t=%0d w=%0d exp p=%b a=%b t=%0d w=%0d",
                         cyc, thresh, match_pulse, alarm, total_cnt, win_cnt,
                         m_pulse, (m_alarm_left > 0), m_total, m_win);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_threshold_alarm();
        test_window_expiry();
        test_held_level();
        test_saturation();
        test_clear();
        test_rst_in_alarm();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/moore_match_monitor.md
MOORE_MATCH_MONITOR -- requirements
Module: moore_match_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8, the width of the match counters and the threshold.
REQ-002 SHALL have parameter WIN, default 16, the window length in clock cycles (≥2).
REQ-003 SHALL have parameter HOLD, default 4, the number of cycles alarm stays asserted (≥1).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port det  input  1  the level output of the upstream Moore sequence detector.
REQ-007 SHALL have port clr  input  1  synchronous clear of counters and FSM.
REQ-008 SHALL have port thresh  input  CNT_W  the window match count that raises alarm; 0 disables alarm.
REQ-009 SHALL have port match_pulse  output  1  a one-cycle pulse per detected match (registered).
REQ-010 SHALL have port total_cnt  output  CNT_W  the saturating count of all matches since reset/clr.
REQ-011 SHALL have port win_cnt  output  CNT_W  the matches counted in the current window.
REQ-012 SHALL have port alarm  output  1  high while in ALARM (registered).

Function
REQ-013 SHALL register det into det_q each cycle; event = det & ~det_q sampled at a rising edge (level held high counts once).
REQ-014 SHALL assert match_pulse for exactly the one cycle following the edge at which event is sampled.
REQ-015 SHALL increment total_cnt on each event, saturating at 2^CNT_W-1, in every state.
REQ-016 SHALL implement FSM states IDLE, WINDOW, ALARM, all encoded in registers.
REQ-017 IDLE: on an event with thresh==1 it SHALL go to ALARM with win_cnt=1; on any other event it SHALL go to WINDOW with win_cnt=1 and timer=0; otherwise it SHALL stay, with win_cnt=0.
REQ-018 WINDOW: timer SHALL increment every cycle; an event SHALL increment win_cnt (saturating).
REQ-019 WINDOW: if the updated win_cnt ≥ thresh and thresh≠0, the FSM SHALL go to ALARM on that same edge.
REQ-020 WINDOW: when timer==WIN-1 and no alarm condition holds, the FSM SHALL go to IDLE and clear win_cnt; an event on that cycle SHALL be counted for the threshold check first but SHALL NOT open a new window.
REQ-021 ALARM: alarm SHALL be 1 for exactly HOLD cycles, after which the FSM SHALL go to IDLE with win_cnt=0; events SHALL update total_cnt and match_pulse but SHALL NOT change win_cnt.
REQ-022 clr SHALL have priority over events: on a clr edge, total_cnt=0, win_cnt=0, timer=0, FSM=IDLE, alarm=0 next cycle, and match_pulse SHALL be suppressed.
REQ-023 A thresh change SHALL take effect at the next event comparison, with no retroactive alarm.
REQ-024 All outputs SHALL be driven directly from registers, with no combinational path from inputs.

Reset
REQ-025 While rst=1, all of the following SHALL be forced immediately, independent of clk: match_pulse=0, total_cnt=0, win_cnt=0, alarm=0, det_q=0, timer=0, hold counter=0, FSM=IDLE.
REQ-026 After rst deasserts, an already-high det SHALL count as an event at the first edge (det_q=0).

Verification
REQ-027 Scenario: thresh=3, single-cycle det pulses at cycles 2, 5, 8 -> three match_pulses; win_cnt 1, 2, 3; alarm=1 for cycles 9-12; then win_cnt=0 and total_cnt=3.
REQ-028 Scenario: thresh=3, det pulses at cycles 0 and 20 -> window expires after 16 cycles; win_cnt returns to 0 before the second pulse; alarm never asserts; total_cnt=2.
REQ-029 Scenario: det held high for 10 cycles, then 0 -> exactly one match_pulse; total_cnt=1; win_cnt=1.
REQ-030 Scenario: 300 events with thresh=0 -> total_cnt saturates at 255 and holds; alarm stays 0 throughout.
REQ-031 Scenario: clr coincident with an event in WINDOW (win_cnt=2) -> no match_pulse; total_cnt=0; win_cnt=0; FSM in IDLE.
REQ-032 Scenario: rst asserted during the 2nd ALARM cycle -> alarm drops to 0 without a clock edge; all counts read 0.
